// File: rtl/exu_pipe_ctrl.sv
// exu_pipe_ctrl: EX-stage pipeline sequencer (stall/flush/bubble control, operand forwarding, perf counters)
module exu_pipe_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       ex_rd,
  input  logic             ex_R_wen,
  input  logic             ex_mem_ren,
  input  logic [4:0]       mem_rd,
  input  logic             mem_R_wen,
  input  logic             ex_redirect,
  input  logic             lsu_busy,
  output logic             pc_stall,
  output logic             id_stall,
  output logic             id_flush,
  output logic             ex_inst_clear,
  output logic             mem_stall,
  output logic [1:0]       fwd_rs1_sel,
  output logic [1:0]       fwd_rs2_sel,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, MEMWAIT = 2'd2} state_t;
  localparam int CW = FLUSH_CYCLES > 1 ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(FLUSH_CYCLES - 1);
  localparam bit MULTI = FLUSH_CYCLES > 1;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic pend_q, pend_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic load_use, stall_v, mstall_v, flush_v;
  logic [1:0] fwd1, fwd2;
  // hazard: the instruction in ID needs a value that EX is still loading from memory
  always_comb begin
    load_use = id_valid & ex_mem_ren & ex_R_wen & (ex_rd != 5'd0) &
               ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));
  end
  // forwarding: EX result is younger and wins over MEM; x0 is never forwarded
  always_comb begin
    fwd1 = (ex_R_wen & ~ex_mem_ren & (ex_rd != 5'd0) & (ex_rd == id_rs1)) ? 2'd1 :
           (mem_R_wen & (mem_rd != 5'd0) & (mem_rd == id_rs1)) ? 2'd2 : 2'd0;
    fwd2 = (ex_R_wen & ~ex_mem_ren & (ex_rd != 5'd0) & (ex_rd == id_rs2)) ? 2'd1 :
           (mem_R_wen & (mem_rd != 5'd0) & (mem_rd == id_rs2)) ? 2'd2 : 2'd0;
  end
  // sequencer next state and raw stall/flush decisions
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    stall_v  = 1'b0;
    mstall_v = 1'b0;
    flush_v  = 1'b0;
    case (state_q)
      RUN: begin
        if (lsu_busy) begin
          stall_v  = 1'b1;
          mstall_v = 1'b1;
          pend_d   = ex_redirect;
          state_d  = MEMWAIT;
        end else if (ex_redirect) begin
          flush_v = 1'b1;
          if (MULTI) begin
            cnt_d   = CNT_LOAD;
            state_d = FLUSH;
          end
        end else if (load_use) begin
          stall_v = 1'b1;
        end
      end
      FLUSH: begin
        flush_v = 1'b1;
        if (lsu_busy) begin
          pend_d  = 1'b1;
          state_d = MEMWAIT;
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = RUN;
        end
      end
      MEMWAIT: begin
        if (lsu_busy) begin
          stall_v  = 1'b1;
          mstall_v = 1'b1;
          pend_d   = pend_q | ex_redirect;
        end else begin
          pend_d  = 1'b0;
          state_d = RUN;
          if (pend_q | ex_redirect) begin
            flush_v = 1'b1;
            if (MULTI) begin
              cnt_d   = CNT_LOAD;
              state_d = FLUSH;
            end
          end
        end
      end
      default: state_d = RUN;
    endcase
  end
  // reset overrides every control output so the pipe holds bubbles while rst is high
  always_comb begin
    pc_stall      = rst | stall_v;
    id_stall      = rst | stall_v;
    ex_inst_clear = rst | stall_v | flush_v;
    id_flush      = ~rst & flush_v;
    mem_stall     = ~rst & mstall_v;
    fwd_rs1_sel   = rst ? 2'd0 : fwd1;
    fwd_rs2_sel   = rst ? 2'd0 : fwd2;
    ctrl_state    = state_q;
    stall_cnt     = stall_cnt_q;
    flush_cnt     = flush_cnt_q;
  end
  // saturating perf counters
  always_comb begin
    stall_cnt_d = (pc_stall & ~&stall_cnt_q) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    flush_cnt_d = (id_flush & ~&flush_cnt_q) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
  end
  // state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
endmodule
